// File: rtl/frequency_meter_pkg.sv
// Shared types and elaboration-time helpers for the frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2
    } meter_state_t;

    function automatic int ceil_log2(input int value);
        int     result;
        longint span;
        result = 0;
        span   = 1;
        while (span < longint'(value)) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int gate_cycles(input int reference_clock, input int gate_divisor);
        return reference_clock / gate_divisor;
    endfunction

endpackage

// File: rtl/frequency_meter_if.sv
// Measurement-side signals of the frequency meter, grouped for port hookup.
interface frequency_meter_if
    import freq_meter_pkg::*;
#(
    parameter int FREQ_BITS = ceil_log2(50_000_000 / 2) + 1
);
    logic                 enable;
    logic                 signal_in;
    logic [FREQ_BITS-1:0] frequency_hz;
    logic                 measure_valid;
    logic                 busy;
    logic                 no_signal;
    logic                 in_tolerance;

    modport master (
        output enable, signal_in,
        input  frequency_hz, measure_valid, busy, no_signal, in_tolerance
    );

    modport slave (
        input  enable, signal_in,
        output frequency_hz, measure_valid, busy, no_signal, in_tolerance
    );
endinterface

// File: rtl/frequency_meter_signal_sync_edge.sv
// Two-flop synchronizer plus history flop; flags a rising edge of an async input.
module signal_sync_edge (
    input  logic clk_FPGA,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);
    logic sync_meta;
    logic sync_stable;
    logic history;

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            history     <= 1'b0;
        end else begin
            sync_meta   <= async_in;
            sync_stable <= sync_meta;
            history     <= sync_stable;
        end
    end

    assign rise_pulse = sync_stable & ~history;
endmodule

// File: rtl/frequency_meter.sv
// Gated edge counter measuring signal_in in Hz against clk_FPGA.
// Optional tolerance flag enabled by defining FREQ_METER_TOLERANCE_EN.
module frequency_meter
    import freq_meter_pkg::*;
#(
    parameter int REFERENCE_CLOCK  = 50_000_000,
    parameter int GATE_DIVISOR     = 10,
    parameter int TARGET_FREQUENCY = 5_000_000,
    parameter int TOLERANCE_HZ     = 1000,
    parameter int FREQ_BITS        = ceil_log2(REFERENCE_CLOCK / 2) + 1
)(
    input logic              clk_FPGA,
    input logic              reset,
    frequency_meter_if.slave meas
);
    localparam int GATE_CYCLES = gate_cycles(REFERENCE_CLOCK, GATE_DIVISOR);
    localparam int GATE_BITS   = (ceil_log2(GATE_CYCLES) < 1) ? 1 : ceil_log2(GATE_CYCLES);
    localparam int EDGE_BITS   = ceil_log2(GATE_CYCLES / 2) + 1;

    if (GATE_DIVISOR < 1 || TARGET_FREQUENCY < 0 || TOLERANCE_HZ < 0) begin : g_bad_params
        $error("frequency_meter: invalid parameter set");
    end

    meter_state_t         state;
    meter_state_t         state_next;
    logic                 arm_cnt;
    logic [GATE_BITS-1:0] gate_cnt;
    logic [EDGE_BITS-1:0] edge_cnt;
    logic [EDGE_BITS-1:0] edge_sum;
    logic [FREQ_BITS-1:0] freq_next;
    logic [FREQ_BITS-1:0] freq_q;
    logic                 valid_q;
    logic                 no_signal_q;
    logic                 rise;
    logic                 terminal;
    logic                 reload;

    signal_sync_edge u_sync (
        .clk_FPGA   (clk_FPGA),
        .reset      (reset),
        .async_in   (meas.signal_in),
        .rise_pulse (rise)
    );

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Terminal cycle both closes the window and, while enabled, opens the next one.
    always_comb begin
        state_next = state;
        terminal   = 1'b0;
        reload     = 1'b0;
        edge_sum   = (edge_cnt == '1) ? edge_cnt : edge_cnt + EDGE_BITS'(rise);
        freq_next  = FREQ_BITS'(longint'(edge_sum) * longint'(GATE_DIVISOR));
        case (state)
            IDLE: if (meas.enable) state_next = ARM;
            ARM: begin
                if (!meas.enable) state_next = IDLE;
                else if (arm_cnt) begin
                    state_next = GATE;
                    reload     = 1'b1;
                end
            end
            GATE: begin
                if (gate_cnt == '0) begin
                    terminal   = 1'b1;
                    reload     = meas.enable;
                    state_next = meas.enable ? GATE : IDLE;
                end else if (!meas.enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            arm_cnt     <= 1'b0;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            freq_q      <= '0;
            valid_q     <= 1'b0;
            no_signal_q <= 1'b0;
        end else begin
            arm_cnt <= (state == ARM) && (state_next == ARM);
            valid_q <= terminal;
            if (reload) begin
                gate_cnt <= GATE_BITS'(GATE_CYCLES - 1);
                edge_cnt <= '0;
            end else if (state == GATE && !terminal) begin
                gate_cnt <= gate_cnt - 1'b1;
                edge_cnt <= edge_sum;
            end
            if (terminal) begin
                freq_q      <= freq_next;
                no_signal_q <= (edge_sum == '0);
            end
        end
    end

`ifdef FREQ_METER_TOLERANCE_EN
    localparam logic [63:0] TARGET_W = 64'(TARGET_FREQUENCY);
    localparam logic [63:0] TOL_W    = 64'(TOLERANCE_HZ);
    localparam logic [63:0] TOL_LOW  = (TARGET_W > TOL_W) ? TARGET_W - TOL_W : 64'd0;
    localparam logic [63:0] TOL_HIGH = TARGET_W + TOL_W;

    logic in_tol_q;

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset)        in_tol_q <= 1'b0;
        else if (terminal) in_tol_q <= (64'(freq_next) >= TOL_LOW) && (64'(freq_next) <= TOL_HIGH);
    end

    assign meas.in_tolerance = in_tol_q;
`else
    assign meas.in_tolerance = 1'b0;
`endif

    assign meas.frequency_hz  = freq_q;
    assign meas.measure_valid = valid_q;
    assign meas.busy          = (state != IDLE);
    assign meas.no_signal     = no_signal_q;
endmodule

// File: tb/tb_frequency_meter.sv
// Directed self-checking bench for frequency_meter with a 1000-cycle/s reference.
module tb_frequency_meter;
    import freq_meter_pkg::*;

    localparam int FB = ceil_log2(1000 / 2) + 1;
`ifdef FREQ_METER_TOLERANCE_EN
    localparam int TOL_ON = 1;
`else
    localparam int TOL_ON = 0;
`endif

    logic clk_FPGA;
    logic reset;
    int   total;
    int   bad;
    int   sig_period;
    int   phase;
    int   cycles;
    bit   seen;

    frequency_meter_if #(.FREQ_BITS(FB)) meas_if ();

    frequency_meter #(
        .REFERENCE_CLOCK  (1000),
        .GATE_DIVISOR     (10),
        .TARGET_FREQUENCY (100),
        .TOLERANCE_HZ     (10),
        .FREQ_BITS        (FB)
    ) dut (
        .clk_FPGA (clk_FPGA),
        .reset    (reset),
        .meas     (meas_if)
    );

    initial begin
        clk_FPGA = 1'b0;
        forever #5 clk_FPGA = ~clk_FPGA;
    end

    // Square wave source stepped on falling edges; period below 2 means held low.
    initial begin
        meas_if.signal_in = 1'b0;
        forever begin
            @(negedge clk_FPGA);
            if (sig_period < 2) begin
                meas_if.signal_in = 1'b0;
            end else begin
                phase = (phase + 1) % sig_period;
                meas_if.signal_in = (phase < sig_period / 2);
            end
        end
    end

    task automatic applyStimulus(input bit en, input int period);
        @(posedge clk_FPGA);
        #2;
        meas_if.enable = en;
        sig_period     = period;
        phase          = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    task automatic waitValid(input int budget, output int n, output bit hit);
        hit = 1'b0;
        n   = 0;
        while (!hit && n < budget) begin
            @(posedge clk_FPGA);
            #1;
            n++;
            if (meas_if.measure_valid === 1'b1) hit = 1'b1;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_freq"},  32'(meas_if.frequency_hz),  32'd0);
        checkOutput({tag, "_valid"}, 32'(meas_if.measure_valid), 32'd0);
        checkOutput({tag, "_busy"},  32'(meas_if.busy),          32'd0);
        checkOutput({tag, "_nosig"}, 32'(meas_if.no_signal),     32'd0);
        checkOutput({tag, "_tol"},   32'(meas_if.in_tolerance),  32'd0);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        sig_period     = 0;
        phase          = 0;
        meas_if.enable = 1'b0;
        reset          = 1'b1;
        #1 reset = 1'b0;
        #2 checkResetOutputs("reset");
        repeat (3) @(posedge clk_FPGA);
        #2 reset = 1'b1;

        // Steady 10-cycle input: 10 edges per 100-cycle window
        applyStimulus(1'b0, 10);
        repeat (20) @(posedge clk_FPGA);
        applyStimulus(1'b1, 10);
        @(posedge clk_FPGA);
        #1 checkOutput("arm_busy", 32'(meas_if.busy), 32'd1);
        waitValid(200, cycles, seen);
        checkOutput("first_seen",   32'(seen), 32'd1);
        checkOutput("first_lat",    32'(cycles), 32'd102);
        checkOutput("steady_freq",  32'(meas_if.frequency_hz), 32'd100);
        checkOutput("steady_nosig", 32'(meas_if.no_signal), 32'd0);
        checkOutput("steady_tol",   32'(meas_if.in_tolerance), 32'(TOL_ON));
        checkOutput("steady_busy",  32'(meas_if.busy), 32'd1);
        waitValid(200, cycles, seen);
        checkOutput("second_lat",   32'(cycles), 32'd100);
        checkOutput("second_freq",  32'(meas_if.frequency_hz), 32'd100);

        // Realign so every later rising edge is detected in a terminal cycle
        phase = 2;
        waitValid(200, cycles, seen);
        checkOutput("align_seen", 32'(seen), 32'd1);
        for (int w = 0; w < 10; w++) begin
            waitValid(200, cycles, seen);
            checkOutput("bound_lat",  32'(cycles), 32'd100);
            checkOutput("bound_freq", 32'(meas_if.frequency_hz), 32'd100);
        end

        // Flat input, then a 4-cycle period
        applyStimulus(1'b1, 0);
        waitValid(200, cycles, seen);
        waitValid(200, cycles, seen);
        checkOutput("flat_seen",  32'(seen), 32'd1);
        checkOutput("flat_freq",  32'(meas_if.frequency_hz), 32'd0);
        checkOutput("flat_nosig", 32'(meas_if.no_signal), 32'd1);
        checkOutput("flat_tol",   32'(meas_if.in_tolerance), 32'd0);
        applyStimulus(1'b1, 4);
        waitValid(200, cycles, seen);
        waitValid(200, cycles, seen);
        checkOutput("p4_seen",  32'(seen), 32'd1);
        checkOutput("p4_freq",  32'(meas_if.frequency_hz), 32'd250);
        checkOutput("p4_nosig", 32'(meas_if.no_signal), 32'd0);
        checkOutput("p4_tol",   32'(meas_if.in_tolerance), 32'd0);

        // Abort halfway through a window, then restart
        repeat (49) @(posedge clk_FPGA);
        applyStimulus(1'b0, 4);
        @(posedge clk_FPGA);
        #1 checkOutput("abort_busy", 32'(meas_if.busy), 32'd0);
        checkOutput("abort_valid", 32'(meas_if.measure_valid), 32'd0);
        waitValid(150, cycles, seen);
        checkOutput("abort_novalid", 32'(seen), 32'd0);
        checkOutput("abort_hold",    32'(meas_if.frequency_hz), 32'd250);
        applyStimulus(1'b1, 4);
        @(posedge clk_FPGA);
        #1 checkOutput("rearm_busy", 32'(meas_if.busy), 32'd1);
        waitValid(200, cycles, seen);
        checkOutput("rearm_lat",  32'(cycles), 32'd102);
        checkOutput("rearm_freq", 32'(meas_if.frequency_hz), 32'd250);

        // Asynchronous reset in the middle of a window
        repeat (30) @(posedge clk_FPGA);
        #3 reset = 1'b0;
        #1 checkResetOutputs("midreset");
        repeat (3) @(posedge clk_FPGA);
        #2 reset = 1'b1;
        @(posedge clk_FPGA);
        #1 checkOutput("post_reset_busy", 32'(meas_if.busy), 32'd1);
        waitValid(200, cycles, seen);
        checkOutput("post_reset_lat",  32'(cycles), 32'd102);
        checkOutput("post_reset_freq", 32'(meas_if.frequency_hz), 32'd250);
        checkOutput("post_reset_tol",  32'(meas_if.in_tolerance), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frequency_meter.md
Name: frequency_meter

Overview:
- Measures the frequency of an external square wave `signal_in` against the FPGA reference clock. It is the measuring counterpart of the team's clock divider, which generates a frequency; this block reads one.
- Counts synchronized rising edges over a fixed gate window derived from `REFERENCE_CLOCK`, then scales the count to Hz.
- Used to check divider outputs and external clocks on board.

Parameters:
- `REFERENCE_CLOCK`, 50_000_000: `clk_FPGA` frequency in Hz.
- `GATE_DIVISOR`, 10: gate window = 1/`GATE_DIVISOR` s, i.e. `GATE_CYCLES` = `REFERENCE_CLOCK`/`GATE_DIVISOR`; result = edges × `GATE_DIVISOR`.
- `TARGET_FREQUENCY`, 5_000_000: expected Hz; used only with the optional feature.
- `TOLERANCE_HZ`, 1000: allowed deviation in Hz; used only with the optional feature.
- `FREQ_BITS`, CeilLog2(`REFERENCE_CLOCK`/2)+1: width of the result.

Ports:
- `clk_FPGA` in 1: reference clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: level; high = continuous back-to-back measurements.
- `signal_in` in 1: asynchronous input to measure.
- `frequency_hz` out `FREQ_BITS`: last completed measurement in Hz.
- `measure_valid` out 1: one-cycle pulse when `frequency_hz` updates.
- `busy` out 1: high in ARM or GATE.
- `no_signal` out 1: last completed window counted 0 edges.
- `in_tolerance` out 1: result within `TARGET_FREQUENCY` ± `TOLERANCE_HZ` (optional feature).

Behaviour:
- Reset (`reset` = 0, asynchronous): state IDLE.
  - `frequency_hz`, `measure_valid`, `busy`, `no_signal`, `in_tolerance`, edge counter, gate counter and synchronizer flops all clear to 0.
  - Reset mid-window discards the partial count.
- Input path: 2-flop synchronizer, then a history flop. A rising edge is sync = 1 and history = 0. Detection latency is 3 `clk_FPGA` cycles after the input transition.
- Measurable range: below `REFERENCE_CLOCK`/2. Higher input frequencies alias; this is not flagged.
- FSM:
  - IDLE: `busy` = 0. When `enable` = 1, go to ARM.
  - ARM: lasts exactly 2 cycles so the synchronizer and history flop hold real samples. No edges are counted. Then go to GATE with gate counter = `GATE_CYCLES`-1 and edge count = 0.
  - GATE: each cycle, the edge count increments on a detected edge and the gate counter decrements.
  - Terminal cycle (gate counter = 0): an edge detected in this cycle is included.
    - Next cycle: `frequency_hz` <= (count + edge) × `GATE_DIVISOR`.
    - `measure_valid` = 1 for exactly that cycle.
    - `no_signal` = (total == 0).
  - Back-to-back windows: in the same terminal cycle, if `enable` = 1, reload the gate counter and clear the edge count with no dead cycle. Windows are contiguous; a detected edge is never dropped or double-counted.
  - If `enable` = 0 at the terminal cycle: latch the result as above, then go to IDLE.
- `enable` falls mid-ARM or mid-GATE: abort to IDLE next cycle. No `measure_valid`; `frequency_hz`, `no_signal` and `in_tolerance` hold their previous values.
- Arithmetic:
  - Edge counter width is CeilLog2(`GATE_CYCLES`/2)+1 and the counter saturates at all-ones.
  - The multiply by `GATE_DIVISOR` is a constant multiply, truncated to `FREQ_BITS`; with defaults it cannot overflow.
- Outputs are registered; no combinational path from `signal_in`.

Optional Feature:
- Macro: `FREQ_METER_TOLERANCE_EN`.
- Defined: `in_tolerance` is registered on the same cycle as `measure_valid`. It is 1 when |`frequency_hz` − `TARGET_FREQUENCY`| <= `TOLERANCE_HZ`, computed with unsigned compares against precomputed bounds `TARGET_FREQUENCY`−`TOLERANCE_HZ` (clamped at 0) and `TARGET_FREQUENCY`+`TOLERANCE_HZ`.
- Not defined: `in_tolerance` is tied to 0; the port still exists. `TARGET_FREQUENCY` and `TOLERANCE_HZ` are unused.

Decomposition:
- Package `freq_meter_pkg` holds:
  - the state enum {IDLE, ARM, GATE};
  - the CeilLog2 function;
  - the gate-cycle constant function (`REFERENCE_CLOCK`/`GATE_DIVISOR`).
- One sub-module, `signal_sync_edge`: 2-flop synchronizer plus history flop. Ports: `clk_FPGA`, `reset`, `async_in`, `rise_pulse`.

Test Plan (`REFERENCE_CLOCK`=1000, `GATE_DIVISOR`=10 → `GATE_CYCLES`=100, `TARGET_FREQUENCY`=100, `TOLERANCE_HZ`=10):
- Steady input: `signal_in` period 10 cycles, `enable`=1 → `measure_valid` every 100 cycles after the first window (first window begins 3 cycles after `enable`); `frequency_hz`=100, `no_signal`=0, `in_tolerance`=1 when the macro is defined.
- Edge on boundary: input rising edge timed so detection lands on the gate terminal cycle → counted in the ending window only; the next window's count starts at 0; 10 consecutive windows each report 100.
- Flat input: `signal_in`=0 → `frequency_hz`=0, `no_signal`=1, `in_tolerance`=0; input period 4 → 250 Hz, `in_tolerance`=0.
- Abort: `enable` dropped at gate cycle 50 → no `measure_valid`, `busy`=0 next cycle, `frequency_hz` holds the prior value; re-enable restarts ARM.
- Reset mid-GATE: `reset`=0 asynchronously → all outputs 0 immediately; after release with `enable`=1, the first result arrives 102 cycles after the first clock edge following release.
- Macro off: same stimulus as the steady-input case → `in_tolerance` constant 0; all other outputs identical.
